// File: rtl/quantized_coefficient_reorder.sv
// Quantized coefficient reorder: raster-tagged quotients into two ping-pong banks, drained in JPEG zigzag order.
// Optional build macro REORDER_DC_DIFF_EN: the zz_index 0 output becomes DC minus the previous drained block's DC.
module quantized_coefficient_reorder #(
  parameter int coeff_width = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   input_valid,
  input  logic [7:0]             tag,
  input  logic [coeff_width-1:0] quotient,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [coeff_width-1:0] coefficient,
  output logic [5:0]             zz_index,
  output logic                   last,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  localparam logic [5:0] zz_table [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  bank_state_t bank_state [2];

  // Write side
  logic       wr_bank;
  logic [5:0] wr_count;
  logic       wr_accept;

  // Read side: issue stage (rd_*), memory-read stage (s1_*), output register
  logic                   rd_bank;
  logic                   rd_active;
  logic [5:0]             rd_pos;
  logic                   rd_issue;
  logic [6:0]             rd_addr;
  logic                   s1_valid;
  logic [coeff_width-1:0] s1_data;
  logic [5:0]             s1_index;
  logic                   s1_bank;
  logic                   s1_load;
  logic                   out_bank;
  logic                   out_load;
  logic                   out_fire;
  logic                   bank_free;
  logic [coeff_width-1:0] dc_adjust;

  logic [coeff_width-1:0] mem [128];

  logic unused_tag_bits;
  assign unused_tag_bits = ^tag[7:6];

  // Output handshake: a beat transfers on a rising edge where output_valid && output_ready;
  // coefficient/zz_index/last only change when the output register is empty or transferring.
  assign out_fire  = output_valid && output_ready;
  assign out_load  = !output_valid || output_ready;
  assign s1_load   = !s1_valid || out_load;
  assign bank_free = out_fire && last;

  assign wr_accept = input_valid &&
                     ((bank_state[wr_bank] == BANK_EMPTY) || (bank_state[wr_bank] == BANK_FILLING));

  // A new block may only start once its bank is FULL; an in-flight block keeps issuing.
  assign rd_issue = s1_load && (rd_active || (bank_state[rd_bank] == BANK_FULL));
  assign rd_addr  = {rd_bank, zz_table[rd_pos]};

  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[{wr_bank, tag[5:0]}] <= quotient;
    end
  end

`ifdef REORDER_DC_DIFF_EN
  logic [coeff_width-1:0] prev_dc;
  logic [coeff_width-1:0] out_raw_dc;

  // prev_dc follows the raw DC that actually left on a handshake, so dropped or
  // reset-discarded blocks never disturb the difference chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_dc    <= '0;
      out_raw_dc <= '0;
    end else begin
      if (out_load && s1_valid) begin
        out_raw_dc <= s1_data;
      end
      if (out_fire && (zz_index == 6'd0)) begin
        prev_dc <= out_raw_dc;
      end
    end
  end

  assign dc_adjust = (s1_index == 6'd0) ? prev_dc : '0;
`else
  assign dc_adjust = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
      wr_bank       <= 1'b0;
      wr_count      <= 6'd0;
      overflow      <= 1'b0;
      rd_bank       <= 1'b0;
      rd_active     <= 1'b0;
      rd_pos        <= 6'd0;
      s1_valid      <= 1'b0;
      s1_data       <= '0;
      s1_index      <= 6'd0;
      s1_bank       <= 1'b0;
      out_bank      <= 1'b0;
      output_valid  <= 1'b0;
      coefficient   <= '0;
      zz_index      <= 6'd0;
      last          <= 1'b0;
    end else begin
      // Completion is counted, not decoded from the tag, so duplicate tags still close a block.
      if (wr_accept) begin
        wr_count <= wr_count + 6'd1;
        if (wr_count == 6'd63) begin
          bank_state[wr_bank] <= BANK_FULL;
          wr_bank             <= ~wr_bank;
        end else begin
          bank_state[wr_bank] <= BANK_FILLING;
        end
      end else if (input_valid) begin
        overflow <= 1'b1;
      end

      if (rd_issue) begin
        if (!rd_active) begin
          bank_state[rd_bank] <= BANK_DRAINING;
        end
        rd_active <= (rd_pos != 6'd63);
        rd_pos    <= rd_pos + 6'd1;
        if (rd_pos == 6'd63) begin
          rd_bank <= ~rd_bank;
        end
      end

      // The bank is only reusable once its last coefficient has left the output register.
      if (bank_free) begin
        bank_state[out_bank] <= BANK_EMPTY;
      end

      if (s1_load) begin
        s1_valid <= rd_issue;
        if (rd_issue) begin
          s1_data  <= mem[rd_addr];
          s1_index <= rd_pos;
          s1_bank  <= rd_bank;
        end
      end

      if (out_load) begin
        output_valid <= s1_valid;
        if (s1_valid) begin
          coefficient <= s1_data - dc_adjust;
          zz_index    <= s1_index;
          last        <= (s1_index == 6'd63);
          out_bank    <= s1_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_quantized_coefficient_reorder.sv
// Directed bench for quantized_coefficient_reorder: latency, zigzag order, stalls, drops and async reset.
// Build with REORDER_DC_DIFF_EN defined to check the DC-difference variant.
module tb_quantized_coefficient_reorder;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         input_valid = 1'b0;
  logic [7:0]   tag = 8'd0;
  logic [W-1:0] quotient = '0;
  logic         output_ready = 1'b1;
  logic         output_valid;
  logic [W-1:0] coefficient;
  logic [5:0]   zz_index;
  logic         last;
  logic         overflow;

  quantized_coefficient_reorder #(.coeff_width(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .input_valid  (input_valid),
    .tag          (tag),
    .quotient     (quotient),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .coefficient  (coefficient),
    .zz_index     (zz_index),
    .last         (last),
    .overflow     (overflow)
  );

  // Clock and cycle stamp
  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  int zz_tb [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  // Scoreboard state
  logic [W-1:0] exp_q [$];
  logic [W-1:0] got_coef [$];
  logic [5:0]   got_idx [$];
  logic         got_last [$];
  int           got_cyc [$];
  int           rd_ptr = 0;
  logic [W-1:0] cur_blk [64];
  logic [W-1:0] prev_dc = '0;
  int           n_checks = 0;
  int           n_pass = 0;

  // Transfers are recorded mid-cycle, one per edge where valid and ready are both high.
  always @(negedge clock) begin
    if (!reset && output_valid && output_ready) begin
      got_coef.push_back(coefficient);
      got_idx.push_back(zz_index);
      got_last.push_back(last);
      got_cyc.push_back(cycle);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Driver tasks
  task automatic send(input logic [7:0] t, input logic [W-1:0] q);
    input_valid = 1'b1;
    tag         = t;
    quotient    = q;
    tick(1);
    input_valid = 1'b0;
  endtask

  task automatic send_block(input bit rev);
    int t;
    for (int r = 0; r < 64; r++) begin
      t = rev ? 63 - r : r;
      send({2'(r), 6'(t)}, cur_blk[t]);
    end
  endtask

  task automatic make_ramp();
    for (int r = 0; r < 64; r++) cur_blk[r] = W'(r);
  endtask

  task automatic make_blk(input int seed, input logic [W-1:0] dc);
    for (int r = 0; r < 64; r++) cur_blk[r] = W'(seed * 97 + r * 13 - 300);
    cur_blk[0] = dc;
  endtask

  task automatic push_exp();
    logic [W-1:0] v;
    for (int k = 0; k < 64; k++) begin
      v = cur_blk[zz_tb[k]];
`ifdef REORDER_DC_DIFF_EN
      if (k == 0) begin
        v       = cur_blk[0] - prev_dc;
        prev_dc = cur_blk[0];
      end
`endif
      exp_q.push_back(v);
    end
  endtask

  task automatic wait_outputs(input int n);
    for (int c = 0; c < 3000 && (got_coef.size() - rd_ptr) < n; c++) tick(1);
    chk("out_count", got_coef.size() - rd_ptr, n);
  endtask

  task automatic compare(input int n);
    logic [W-1:0] e;
    int p;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      p = rd_ptr + i;
      if (p < got_coef.size()) begin
        chk($sformatf("coef[%0d]", i), got_coef[p], e);
        chk($sformatf("zz_index[%0d]", i), got_idx[p], i % 64);
        chk($sformatf("last[%0d]", i), got_last[p], (i % 64) == 63);
      end else begin
        chk($sformatf("missing[%0d]", i), got_coef.size(), p + 1);
      end
    end
    rd_ptr = rd_ptr + n;
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_valid", output_valid, 0);
    chk("rst_coef", coefficient, 0);
    chk("rst_zz", zz_index, 0);
    chk("rst_last", last, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;
    tick(2);

    // Ramp block: first valid two clocks after the 64th write, values follow zigzag
    make_ramp();
    push_exp();
    send_block(1'b0);
    chk("lat_edge0", output_valid, 0);
    tick(1);
    chk("lat_edge1", output_valid, 0);
    tick(1);
    chk("lat_edge2", output_valid, 1);
    chk("lat_first_coef", coefficient, 0);
    wait_outputs(64);
    chk("ramp_pos3", got_coef[rd_ptr + 3], 16);
    chk("ramp_pos9", got_coef[rd_ptr + 9], 24);
    compare(64);

    // DC values 10, 25, 20
    make_blk(1, 16'd10); push_exp(); send_block(1'b0); tick(2);
    make_blk(2, 16'd25); push_exp(); send_block(1'b0); tick(2);
    make_blk(3, 16'd20); push_exp(); send_block(1'b0); tick(2);
    wait_outputs(192);
`ifdef REORDER_DC_DIFF_EN
    chk("dc_blk0", got_coef[rd_ptr], 16'd10);
    chk("dc_blk1", got_coef[rd_ptr + 64], 16'd15);
    chk("dc_blk2", got_coef[rd_ptr + 128], 16'hfffb);
`else
    chk("dc_blk0", got_coef[rd_ptr], 16'd10);
    chk("dc_blk1", got_coef[rd_ptr + 64], 16'd25);
    chk("dc_blk2", got_coef[rd_ptr + 128], 16'd20);
`endif
    compare(192);
    chk("dc_overflow", overflow, 0);

    // Three streamed blocks; the third starts right after the 64th write of the second,
    // which lands on the same edge as the first bank's final transfer.
    make_blk(4, 16'd100); push_exp(); send_block(1'b0); tick(2);
    make_blk(5, 16'hff00); push_exp(); send_block(1'b0);
    make_blk(6, 16'd7); push_exp(); send_block(1'b0);
    wait_outputs(192);
    chk("no_bubble", got_cyc[rd_ptr + 128] - got_cyc[rd_ptr + 127], 1);
    compare(192);
    chk("stream_overflow", overflow, 0);

    // Stall: one block held, one buffered, one dropped
    output_ready = 1'b0;
    make_blk(7, 16'd5); push_exp(); send_block(1'b0);
    tick(2);
    chk("stall_valid", output_valid, 1);
    chk("stall_coef_first", coefficient, exp_q[0]);
    make_blk(8, 16'hfff9); push_exp(); send_block(1'b0);
    make_blk(9, 16'd1234); send_block(1'b0);
    chk("stall_overflow", overflow, 1);
    tick(70);
    chk("stall_coef_held", coefficient, exp_q[0]);
    chk("stall_zz_held", zz_index, 0);
    chk("stall_no_transfer", got_coef.size() - rd_ptr, 0);
    output_ready = 1'b1;
    wait_outputs(128);
    compare(128);
    chk("overflow_sticky", overflow, 1);

    // Async reset between edges with a full block pending and a partial one filling
    output_ready = 1'b0;
    make_blk(10, 16'd3); send_block(1'b0);
    for (int r = 0; r < 20; r++) send(8'(r), W'(r + 500));
    tick(2);
    chk("pre_reset_valid", output_valid, 1);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", output_valid, 0);
    chk("mid_rst_coef", coefficient, 0);
    chk("mid_rst_zz", zz_index, 0);
    chk("mid_rst_last", last, 0);
    chk("mid_rst_overflow", overflow, 0);
    tick(2);
    reset = 1'b0;
    prev_dc = '0;
    output_ready = 1'b1;
    tick(10);
    chk("post_rst_idle", output_valid, 0);

    // Reverse tag order after reset matches the ramp block output
    make_ramp();
    push_exp();
    send_block(1'b1);
    wait_outputs(64);
    chk("rev_pos2", got_coef[rd_ptr + 2], 8);
    compare(64);
    tick(5);
    chk("rev_no_extra", got_coef.size() - rd_ptr, 0);
    chk("final_overflow", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
